// File: rtl/pipe_alu_pkg.sv
// pipe_alu_pkg: opcode and FSM encodings shared by pipe_alu and its multiplier.
package pipe_alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_NOT  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_BEQZ = 4'd6,
    ALU_BNEZ = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_SUB  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SLT  = 4'd11,
    ALU_MUL  = 4'd12
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/pipe_alu_mul.sv
// pipe_alu_mul: iterative signed shift-add multiplier, one partial product per cycle.
// Magnitudes are accumulated; the sign is applied combinationally on the last step
// so the parent can register the product on the same edge as that step.
module pipe_alu_mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] product_c,
  output logic             ovf_c
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [PW-1:0]    mag_a_q;
  logic [PW-1:0]    acc_q;
  logic [WIDTH-1:0] mag_b_q;
  logic             neg_q;
  logic             running_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic [PW-1:0]    acc_next_c;
  logic [PW-1:0]    full_c;

  assign abs_a_c    = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign abs_b_c    = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign acc_next_c = acc_q + (mag_b_q[0] ? mag_a_q : '0);
  assign full_c     = neg_q ? (~acc_next_c + PW'(1)) : acc_next_c;

  assign done_c    = running_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign product_c = full_c[WIDTH-1:0];
  // Representable in WIDTH signed bits only if the top WIDTH+1 bits are all equal.
  assign ovf_c     = !((&full_c[PW-1:WIDTH-1]) || !(|full_c[PW-1:WIDTH-1]));

  // Load magnitudes on start, then one shift-add step per cycle for WIDTH cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a_q   <= '0;
      acc_q     <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else if (clr) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else if (start) begin
      mag_a_q   <= PW'(abs_a_c);
      mag_b_q   <= abs_b_c;
      acc_q     <= '0;
      neg_q     <= a[WIDTH-1] ^ b[WIDTH-1];
      running_q <= 1'b1;
      cnt_q     <= '0;
    end else if (running_q) begin
      acc_q   <= acc_next_c;
      mag_a_q <= mag_a_q << 1;
      mag_b_q <= mag_b_q >> 1;
      if (done_c) begin
        running_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_alu.sv
// pipe_alu: registered ALU with valid/ready handshakes and a tag sideband.
// Optional iterative multiplier on opcode 12 is enabled by PIPE_ALU_MUL_EN.
module pipe_alu
  import pipe_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_ovf,
  output logic             out_branch,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned MSB  = WIDTH - 1;
  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [SH_W-1:0]  sh_c;
  logic             sh_big_c;
  logic [WIDTH-1:0] alu_f_c;
  logic             alu_ovf_c;
  logic             alu_br_c;
  logic             accept_c;

  assign sum_c    = in_a + in_b;
  assign diff_c   = in_a - in_b;
  assign sh_c     = in_b[SH_W-1:0];
  assign sh_big_c = (in_b >= WIDTH'(WIDTH));
  assign accept_c = in_valid && in_ready;

  // Single-cycle datapath; opcode 12 and undefined opcodes yield zero here.
  always_comb begin
    alu_f_c   = '0;
    alu_ovf_c = 1'b0;
    alu_br_c  = 1'b0;
    case (alu_op_e'(in_op))
      ALU_ADD: begin
        alu_f_c   = sum_c;
        alu_ovf_c = (in_a[MSB] == in_b[MSB]) && (sum_c[MSB] != in_a[MSB]);
      end
      ALU_SUB: begin
        alu_f_c   = diff_c;
        alu_ovf_c = (in_a[MSB] != in_b[MSB]) && (diff_c[MSB] != in_a[MSB]);
      end
      ALU_NOT:  alu_f_c = ~in_b;
      ALU_AND:  alu_f_c = in_a & in_b;
      ALU_OR:   alu_f_c = in_a | in_b;
      ALU_XOR:  alu_f_c = in_a ^ in_b;
      ALU_SRA:  alu_f_c = sh_big_c ? {WIDTH{in_a[MSB]}} : WIDTH'($signed(in_a) >>> sh_c);
      ALU_SLL:  alu_f_c = sh_big_c ? '0 : (in_a << sh_c);
      ALU_SRL:  alu_f_c = sh_big_c ? '0 : (in_a >> sh_c);
      ALU_SLT:  alu_f_c = WIDTH'($signed(in_a) < $signed(in_b));
      ALU_BEQZ: alu_br_c = (in_a == '0);
      ALU_BNEZ: alu_br_c = (in_a != '0);
      default: ;
    endcase
  end

`ifdef PIPE_ALU_MUL_EN
  alu_state_e       state_q;
  logic [TAG_W-1:0] tag_q;
  logic             is_mul_c;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_f_c;
  logic             mul_ovf_c;

  assign is_mul_c = (alu_op_e'(in_op) == ALU_MUL);
  assign in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready) && !flush;

  pipe_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .start     (accept_c && is_mul_c),
    .a         (in_a),
    .b         (in_b),
    .done_c    (mul_done_c),
    .product_c (mul_f_c),
    .ovf_c     (mul_ovf_c)
  );
`else
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign busy     = 1'b0;
`endif

  // Control FSM and result register; a consumed result may be replaced on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_f      <= '0;
      out_ovf    <= 1'b0;
      out_branch <= 1'b0;
      out_zero   <= 1'b0;
      out_tag    <= '0;
`ifdef PIPE_ALU_MUL_EN
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      tag_q      <= '0;
`endif
    end else if (flush) begin
      out_valid  <= 1'b0;
`ifdef PIPE_ALU_MUL_EN
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
`ifdef PIPE_ALU_MUL_EN
      if (state_q == ST_MUL) begin
        if (mul_done_c) begin
          out_valid  <= 1'b1;
          out_f      <= mul_f_c;
          out_ovf    <= mul_ovf_c;
          out_branch <= 1'b0;
          out_zero   <= (mul_f_c == '0);
          out_tag    <= tag_q;
          state_q    <= ST_IDLE;
          busy       <= 1'b0;
        end
      end else if (accept_c && is_mul_c) begin
        state_q <= ST_MUL;
        busy    <= 1'b1;
        tag_q   <= in_tag;
      end else
`endif
      if (accept_c) begin
        out_valid  <= 1'b1;
        out_f      <= alu_f_c;
        out_ovf    <= alu_ovf_c;
        out_branch <= alu_br_c;
        out_zero   <= (alu_f_c == '0);
        out_tag    <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
// tb_pipe_alu: directed and random stimulus for pipe_alu (WIDTH=16, TAG_W=4) with a result scoreboard.
module tb_pipe_alu;
  import pipe_alu_pkg::*;

  typedef struct packed {
    logic [15:0] f;
    logic        ovf;
    logic        br;
    logic        zr;
    logic [3:0]  tag;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_f;
  logic        out_ovf;
  logic        out_branch;
  logic        out_zero;
  logic [3:0]  out_tag;
  logic        busy;

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];

  pipe_alu #(.WIDTH(16), .TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_ovf    (out_ovf),
    .out_branch (out_branch),
    .out_zero   (out_zero),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference model in integer arithmetic, independent of the bit-level datapath.
  function automatic res_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] tag);
    res_t e;
    int sa, sbv, r;
    e = '0;
    e.tag = tag;
    sa = $signed(a);
    sbv = $signed(b);
    case (op)
      4'd0: begin r = sa + sbv; e.f = r[15:0]; e.ovf = (r > 32767) || (r < -32768); end
      4'd1: e.f = ~b;
      4'd2: e.f = a & b;
      4'd3: e.f = a | b;
      4'd4: begin r = sa >>> ((b >= 16) ? 15 : int'(b[3:0])); e.f = r[15:0]; end
      4'd5: begin r = int'(a) << b[3:0]; e.f = (b >= 16) ? 16'h0 : r[15:0]; end
      4'd6: e.br = (a == 16'h0);
      4'd7: e.br = (a != 16'h0);
      4'd8: e.f = a ^ b;
      4'd9: begin r = sa - sbv; e.f = r[15:0]; e.ovf = (r > 32767) || (r < -32768); end
      4'd10: e.f = (b >= 16) ? 16'h0 : (a >> b[3:0]);
      4'd11: e.f = (sa < sbv) ? 16'h1 : 16'h0;
`ifdef PIPE_ALU_MUL_EN
      4'd12: begin r = sa * sbv; e.f = r[15:0]; e.ovf = (r > 32767) || (r < -32768); end
`endif
      default: ;
    endcase
    e.zr = (e.f == 16'h0);
    return e;
  endfunction

  // Scoreboard: compare each result as it is consumed.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      res_t o;
      res_t e;
      o = '{out_f, out_ovf, out_branch, out_zero, out_tag};
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", 32'(o), 32'(e));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] tag, input bit push, input res_t exp);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_wait", 32'(n), 32'd0);
    if (push) sb.push_back(exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    res_t e;
    logic [3:0] op;
    logic [15:0] a, b;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'({out_valid, busy, out_f, out_ovf, out_branch, out_zero, out_tag}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    // Overflow cases, one-cycle latency
    issue(4'(ALU_ADD), 16'h7FFF, 16'h0001, 4'h1, 1'b1, '{16'h8000, 1'b1, 1'b0, 1'b0, 4'h1});
    check("add_latency", 32'({out_valid, out_f}), {15'd0, 1'b1, 16'h8000});
    issue(4'(ALU_SUB), 16'h8000, 16'h0001, 4'h2, 1'b1, '{16'h7FFF, 1'b1, 1'b0, 1'b0, 4'h2});

    // Shifts including out-of-range amounts
    issue(4'(ALU_SRA), 16'h8000, 16'd4,  4'h3, 1'b1, '{16'hF800, 1'b0, 1'b0, 1'b0, 4'h3});
    issue(4'(ALU_SRA), 16'h8000, 16'd20, 4'h4, 1'b1, '{16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h4});
    issue(4'(ALU_SLL), 16'h0001, 16'd16, 4'h5, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1, 4'h5});
    issue(4'(ALU_SRL), 16'h8000, 16'd15, 4'h6, 1'b1, '{16'h0001, 1'b0, 1'b0, 1'b0, 4'h6});
    wait_drain();

`ifdef PIPE_ALU_MUL_EN
    // Multiply: busy window, in_ready low, result at accept+16
    issue(4'(ALU_MUL), 16'hFFFD, 16'd7, 4'h7, 1'b1, '{16'hFFEB, 1'b0, 1'b0, 1'b0, 4'h7});
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (!(busy && !out_valid && !in_ready)) bad++;
      @(posedge clk);
      #1;
    end
    check("mul_busy_window", 32'(bad), 32'd0);
    check("mul_done", 32'({out_valid, busy}), 32'b10);
    issue(4'(ALU_MUL), 16'h0100, 16'h0100, 4'h8, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 4'h8});
    wait_drain();
`else
    // Multiplier absent: opcode 12 is a single-cycle zero
    issue(4'(ALU_MUL), 16'd3, 16'd3, 4'h7, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1, 4'h7});
    check("mul_off_single", 32'({out_valid, busy}), 32'b10);
    wait_drain();
`endif

    // Backpressure: stalled BNEZ holds, then back-to-back XOR replaces it
    out_ready = 1'b0;
    issue(4'(ALU_BNEZ), 16'd5, 16'd0, 4'hA, 1'b1, '{16'h0000, 1'b0, 1'b1, 1'b1, 4'hA});
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (!(out_valid && out_f == 16'h0 && out_branch && out_zero && out_tag == 4'hA && !in_ready)) bad++;
      @(posedge clk);
      #1;
    end
    check("stall_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    issue(4'(ALU_XOR), 16'h00FF, 16'h0F0F, 4'hB, 1'b1, '{16'h0FF0, 1'b0, 1'b0, 1'b0, 4'hB});
    check("b2b_no_bubble", 32'({out_valid, out_tag}), {27'd0, 1'b1, 4'hB});
    wait_drain();

    // Flush drops an unconsumed result
    out_ready = 1'b0;
    issue(4'(ALU_ADD), 16'd1, 16'd2, 4'hC, 1'b0, '0);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_result", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

`ifdef PIPE_ALU_MUL_EN
    // Flush mid-multiply
    issue(4'(ALU_MUL), 16'd100, 16'd100, 4'hD, 1'b0, '0);
    repeat (4) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_mul", 32'({out_valid, busy, in_ready}), 32'b001);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (out_valid || busy) bad++;
    end
    check("flush_mul_quiet", 32'(bad), 32'd0);

    // Asynchronous reset mid-multiply
    issue(4'(ALU_MUL), 16'd100, 16'd100, 4'hE, 1'b0, '0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
`else
    // Asynchronous reset with a result held
    out_ready = 1'b0;
    issue(4'(ALU_ADD), 16'd100, 16'd100, 4'hE, 1'b0, '0);
    #2 rst_n = 1'b0;
`endif
    #1;
    check("async_reset", 32'({out_valid, busy, out_f, out_ovf, out_branch, out_zero, out_tag}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;

    // Random operations checked against the model
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = 16'($urandom);
      if (op == 4'd4 || op == 4'd5 || op == 4'd10) b = 16'($urandom_range(0, 20));
      if ((op == 4'd6 || op == 4'd7) && i[0]) a = 16'h0;
      e = model(op, a, b, 4'(i));
      issue(op, a, b, 4'(i), 1'b1, e);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_alu.md
Name: pipe_alu

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU, for the next core generation.
- Adds WIDTH/TAG_W parameters, valid/ready handshakes on input and output, and a registered result stage.
- Adds a multi-cycle iterative signed multiplier, plus SUB/SRL/SLT opcodes and a zero flag.
- Sits between the operand-fetch stage and writeback/branch-resolve; the tag carries the destination register ID.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- TAG_W, 4, width of the sideband tag passed from input to output.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; kills in-flight MUL and any unconsumed result.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted when in_valid & in_ready at a rising edge.
- in_op  input  4  opcode.
- in_a  input  WIDTH  signed operand a.
- in_b  input  WIDTH  signed operand b.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer takes the result when out_valid & out_ready.
- out_f  output  WIDTH  result.
- out_ovf  output  1  signed overflow.
- out_branch  output  1  branch-taken flag.
- out_zero  output  1  out_f == 0.
- out_tag  output  TAG_W  tag of the result.
- busy  output  1  multiplier iterating.

Behaviour:
- Reset: out_valid=0, out_f=0, out_ovf=0, out_branch=0, out_zero=0, out_tag=0, busy=0, FSM=IDLE, iteration counter=0.
- Opcodes:
  - 0 ADD a+b.
  - 1 NOT ~b.
  - 2 AND.
  - 3 OR.
  - 4 SRA a>>>sh.
  - 5 SLL a<<sh.
  - 6 BEQZ: f=0, branch=(a==0).
  - 7 BNEZ: f=0, branch=(a!=0).
  - 8 XOR.
  - 9 SUB a-b.
  - 10 SRL logical a>>sh.
  - 11 SLT: f=1 if a<b signed, else 0.
  - 12 MUL.
  - 13-15: f=0, all flags 0.
- Shift amount sh = b interpreted unsigned. If b >= WIDTH: SLL/SRL give 0, SRA gives WIDTH copies of a[MSB].
- ovf, ADD: a,b same sign and f sign differs.
- ovf, SUB: a,b signs differ and f sign differs from a.
- ovf, MUL: the full 2*WIDTH signed product is not representable in WIDTH bits.
- ovf is 0 for every other opcode. out_branch is 0 except for opcodes 6/7. out_zero is always computed from out_f.
- in_ready = (FSM==IDLE) & (!out_valid | out_ready) & !flush.
- Single-cycle op accepted at edge k: result and tag are registered at edge k, so out_valid is high in cycle k+1.
- FSM states IDLE, MUL.
  - IDLE -> MUL when a MUL is accepted at edge k: operands captured, busy=1.
  - Exactly WIDTH shift-add steps follow (shift-add on magnitudes, sign corrected at the final step).
  - At edge k+WIDTH the result is written, out_valid=1, FSM -> IDLE.
- Result register: out_valid held, and out_f/flags/tag stable, until out_valid & out_ready.
- Back-to-back: the same edge may consume the old result and register a new single-cycle result, so out_valid stays 1.
- No new op is accepted while in MUL, or while a result is stalled (out_ready=0).
- flush=1 at an edge: out_valid->0, FSM->IDLE, busy->0, counter->0, nothing accepted. Output data registers keep their values (don't-care).
- Reset asserted mid-MUL: all state returns to reset values immediately (asynchronous); no result is produced.
- All arithmetic is in WIDTH bits, wrapping. The MUL product is the low WIDTH bits of the exact signed product.

Optional Feature:
- Macro PIPE_ALU_MUL_EN.
- Defined: opcode 12 is the iterative multiplier as above; FSM and counter are present.
- Undefined: opcode 12 is single-cycle, f=0, flags 0. busy is tied to 0, the FSM is removed, and in_ready = (!out_valid | out_ready) & !flush.

Decomposition:
- Shared package pipe_alu_pkg: opcode enum alu_op_e (ALU_ADD..ALU_MUL with the values above), FSM enum alu_state_e {ST_IDLE, ST_MUL}.
- Sub-module pipe_alu_mul: iterative signed shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done pulse, product low WIDTH bits, ovf.
  - Instantiated only under PIPE_ALU_MUL_EN.
  - The parent owns the handshake and the result register.

Test Plan (WIDTH=16, out_ready=1 unless stated):
- Overflow: ADD 0x7FFF+0x0001 -> out_f=0x8000, ovf=1, out_valid one cycle after accept. SUB 0x8000-0x0001 -> 0x7FFF, ovf=1.
- Shifts: SRA 0x8000 by 4 -> 0xF800. SRA 0x8000 by 20 -> 0xFFFF. SLL 0x0001 by 16 -> 0x0000. SRL 0x8000 by 15 -> 0x0001.
- Multiply: MUL -3*7 -> 0xFFEB, ovf=0; busy=1 for 16 cycles, out_valid at edge accept+16, in_ready=0 throughout. MUL 0x0100*0x0100 -> 0x0000, ovf=1.
- Backpressure: out_ready=0 with BNEZ a=5 (branch=1, tag=0xA) stalled 3 cycles -> outputs stable, in_ready=0. Then out_ready=1 with back-to-back XOR 0x00FF^0x0F0F -> 0x0FF0, tag advances with no bubble.
- Flush/reset: MUL 100*100 with flush at step 5 -> no out_valid, busy=0, in_ready=1 next cycle. Same MUL with rst_n low at step 8 -> all outputs 0 immediately.
- Macro off: MUL 3*3 -> out_f=0, ovf=0, single-cycle, busy never 1.
